mmio_fabric: RTL and testbench
==============================

# mmio_fabric

Parametrised memory-mapped I/O fabric between the `cpu` memory port (`addr`, `mm_we`, `mm_re`, `wdata`, `rdata`) and up to N peripheral slots, such as the SPART register window and the BMP display window. It replaces hand-written per-address decode with:
- a base/span slot map,
- a registered one-hot peripheral select,
- a per-slot ready handshake that stalls the CPU,
- a bus timeout with a readable and clearable error status register.

## Interface
Parameters:
- N_SLOTS, 4, number of peripheral slots (1..16)
- BASE_ADDR, 16'hC004, first address of slot 0; must be aligned to SLOT_SPAN
- SLOT_SPAN, 4, addresses per slot; power of two, ≥2; slot k covers BASE_ADDR+k*SLOT_SPAN .. +SLOT_SPAN-1
- STATUS_ADDR, 16'hC03F, fabric status register address; must lie outside all slots
- TIMEOUT, 255, maximum WAIT cycles before an access is aborted (1..255)
- UNMAPPED_DATA, 16'hA5A5, read value for unmapped addresses

Ports (AW = $clog2(SLOT_SPAN)):
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_addr  in  16  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data
- cpu_stall  out  1  CPU must hold its request while high
- per_sel  out  N_SLOTS  registered one-hot slot select
- per_we  out  1  registered write strobe
- per_re  out  1  registered read strobe
- per_addr  out  AW  registered offset within the slot
- per_wdata  out  16  registered write data
- per_rdata  in  16*N_SLOTS  slot k read data on bits [16k+15:16k]
- per_ready  in  N_SLOTS  slot k completes the access (read data valid) when high
- err_flag  out  1  high while err_count != 0

## Operation
- State machine: IDLE, WAIT, DONE.
- Request = cpu_we | cpu_re.
- If cpu_we and cpu_re are both high, the access is a write: per_we=1, per_re=0.
- **IDLE, request hits slot k:**
  - cpu_stall=1 combinationally in that cycle.
  - Latch per_addr=cpu_addr[AW-1:0] and per_wdata, set per_sel[k] and per_we/per_re, then go to WAIT.
  - Clear wait_cnt.
- **IDLE, request at STATUS_ADDR:** no stall.
  - Read: cpu_rdata={err_count[7:0], last_err_slot[7:0]} combinationally.
  - Write: clears err_count and last_err_slot at the next edge.
- **IDLE, request at any other address:** no stall. A read returns UNMAPPED_DATA combinationally. A write is ignored.
- **WAIT:** cpu_stall=1. Strobes are held. wait_cnt increments each cycle.
  - per_ready[k]=1: capture the per_rdata slice k into rd_q and go to DONE. per_ready of unselected slots is ignored.
  - No ready and wait_cnt==TIMEOUT-1: abort.
    - rd_q=16'hDEAD.
    - err_count increments, saturating at 255.
    - last_err_slot=k.
    - Go to DONE.
- **DONE:** strobes and per_sel are 0. cpu_stall=0. cpu_rdata=rd_q (for a write, rd_q is still driven and the CPU ignores it). The CPU treats this cycle as completion. Next state is IDLE unconditionally. A request still present in DONE is consumed and is not re-issued.
- A status write cannot coincide with a timeout, because the CPU is stalled during WAIT.

## Timing
- Reset: state=IDLE, per_sel=0, per_we=0, per_re=0, per_addr=0, per_wdata=0, rd_q=0, err_count=0, last_err_slot=0, wait_cnt=0. Outputs after reset: cpu_stall=0, err_flag=0. cpu_rdata=UNMAPPED_DATA while there is no request.
- Slot access, ready immediate:
  - Cycle 0: request seen, stall=1.
  - Cycle 1: strobes high, ready=1, stall=1.
  - Cycle 2: DONE, stall=0, data valid.
  - Total 3 cycles, 2 stalled.
- Each cycle of ready delay adds one stalled cycle.
- Timeout: strobes are high for exactly TIMEOUT cycles, then DONE with 16'hDEAD.
- Status and unmapped accesses: 0 wait cycles.
- rst asserted during WAIT: next edge returns to IDLE with strobes dropped. The access is lost and is not counted as an error.

## Test plan
- Read slot 1 (0xC008, N_SLOTS=4, SPAN=4), slot 1 ready in its first WAIT cycle with data 0x1234 -> per_sel=4'b0010, per_addr=0, per_re=1 for 1 cycle; cpu_stall high 2 cycles; cpu_rdata=0x1234 in DONE.
- Write 0xBEEF to 0xC00F, slot 2 ready after 3 cycles -> per_sel=4'b0100, per_addr=3, per_we=1 and per_wdata=0xBEEF held 3 cycles; stall high 4 cycles; per_re never asserted.
- Read 0xC001 and write 0xC030 -> no stall, no per_sel; the read returns 0xA5A5.
- Read slot 3 with ready never asserted, TIMEOUT=8 -> strobes high 8 cycles, cpu_rdata=0xDEAD, err_flag=1. A status read then returns 0x0103; a status write clears it, so a subsequent status read returns 0x0000 and err_flag=0.
- 300 forced timeouts on slot 0 -> err_count saturates at 0xFF; status read returns 0xFF00.
- rst pulsed in the second WAIT cycle of a slot read -> next cycle all strobes are 0 and stall=0; err_count is unchanged. A following access completes normally.

Source files
------------

// File: rtl/mmio_fabric.sv
// MMIO fabric: decodes the CPU memory port onto N base/span peripheral slots,
// stalls the CPU until the selected slot is ready, and aborts hung accesses.
module mmio_fabric #(
  parameter int          N_SLOTS       = 4,
  parameter logic [15:0] BASE_ADDR     = 16'hC004,
  parameter int          SLOT_SPAN     = 4,
  parameter logic [15:0] STATUS_ADDR   = 16'hC03F,
  parameter int          TIMEOUT       = 255,
  parameter logic [15:0] UNMAPPED_DATA = 16'hA5A5,
  localparam int         AW            = $clog2(SLOT_SPAN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cpu_addr,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [15:0]            cpu_wdata,
  output logic [15:0]            cpu_rdata,
  output logic                   cpu_stall,
  output logic [N_SLOTS-1:0]     per_sel,
  output logic                   per_we,
  output logic                   per_re,
  output logic [AW-1:0]          per_addr,
  output logic [15:0]            per_wdata,
  input  logic [16*N_SLOTS-1:0]  per_rdata,
  input  logic [N_SLOTS-1:0]     per_ready,
  output logic                   err_flag
);

  localparam logic [16:0] SPAN_TOT = 17'(N_SLOTS * SLOT_SPAN);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [15:0] rd_q;
  logic [7:0]  err_count;
  logic [7:0]  last_err_slot;
  logic [7:0]  wait_cnt;
  logic [3:0]  sel_idx;

  logic        req, hit, is_status, ready_hit;
  logic [16:0] offs;
  logic [3:0]  hit_idx;
  logic [15:0] slot_rd;

  // Addresses below BASE_ADDR wrap to a large 17-bit offset and miss the range check.
  assign offs      = {1'b0, cpu_addr} - {1'b0, BASE_ADDR};
  assign hit       = offs < SPAN_TOT;
  assign hit_idx   = offs[AW +: 4];
  assign req       = cpu_we | cpu_re;
  assign is_status = cpu_addr == STATUS_ADDR;
  assign ready_hit = |(per_ready & per_sel);
  assign err_flag  = err_count != 8'd0;
  assign cpu_stall = (state == S_WAIT) || (state == S_IDLE && req && hit);

  always_comb begin
    slot_rd = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (per_sel[k]) slot_rd = slot_rd | per_rdata[16*k +: 16];
  end

  always_comb begin
    cpu_rdata = UNMAPPED_DATA;
    if (state == S_DONE)
      cpu_rdata = rd_q;
    else if (state == S_IDLE && cpu_re && !cpu_we && is_status)
      cpu_rdata = {err_count, last_err_slot};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      per_sel       <= '0;
      per_we        <= 1'b0;
      per_re        <= 1'b0;
      per_addr      <= '0;
      per_wdata     <= '0;
      rd_q          <= '0;
      err_count     <= '0;
      last_err_slot <= '0;
      wait_cnt      <= '0;
      sel_idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && hit) begin
            per_sel   <= N_SLOTS'(1) << hit_idx;
            per_we    <= cpu_we;
            per_re    <= cpu_re & ~cpu_we;
            per_addr  <= cpu_addr[AW-1:0];
            per_wdata <= cpu_wdata;
            sel_idx   <= hit_idx;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end else if (cpu_we && is_status) begin
            err_count     <= '0;
            last_err_slot <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (ready_hit || wait_cnt == TO_LAST) begin
            per_sel <= '0;
            per_we  <= 1'b0;
            per_re  <= 1'b0;
            state   <= S_DONE;
            if (ready_hit) begin
              rd_q <= slot_rd;
            end else begin
              rd_q          <= 16'hDEAD;
              last_err_slot <= {4'b0, sel_idx};
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;  // DONE: a lingering request is consumed, not replayed
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fabric.sv
// Bench for mmio_fabric: table of CPU accesses with a behavioural slot model,
// expected results queued at drive time and checked on completion.
module tb_mmio_fabric;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       cpu_addr, cpu_wdata, cpu_rdata, per_wdata;
  logic              cpu_we, cpu_re, cpu_stall, per_we, per_re, err_flag;
  logic [N-1:0]      per_sel, per_ready;
  logic [1:0]        per_addr;
  logic [16*N-1:0]   per_rdata = {16'h3333, 16'h2222, 16'h1234, 16'h0F0F};

  always #5 clk = ~clk;

  mmio_fabric #(.N_SLOTS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .per_sel(per_sel), .per_we(per_we), .per_re(per_re), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ready(per_ready),
    .err_flag(err_flag)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [15:0] wdata;
    int          dly;     // WAIT cycle in which the slot raises ready; -1 = never
    logic        chk_rd;
    logic [15:0] rdata;
    int          stall;
    logic [3:0]  sel;
    logic [1:0]  paddr;
    int          we_cyc;
    int          re_cyc;
    logic        err;     // err_flag one cycle after completion
  } vec_t;

  vec_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(logic [15:0] addr, logic we, logic re, logic [15:0] wdata,
                              int dly, logic chk_rd, logic [15:0] rdata, int stall,
                              logic [3:0] sel, logic [1:0] paddr, int we_cyc, int re_cyc,
                              logic err);
    vec_t v;
    v.addr = addr; v.we = we; v.re = re; v.wdata = wdata; v.dly = dly;
    v.chk_rd = chk_rd; v.rdata = rdata; v.stall = stall; v.sel = sel;
    v.paddr = paddr; v.we_cyc = we_cyc; v.re_cyc = re_cyc; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one CPU access and models the selected slot's ready timing.
  task automatic access(input vec_t v, input string tag);
    vec_t        e;
    int          stall_n, we_n, re_n, wc;
    logic [3:0]  sel_o;
    logic [1:0]  a_o;
    logic [15:0] wd_o, rd_o;
    logic        done_clean;
    bit          ok;
    sb.push_back(v);
    cpu_addr = v.addr; cpu_we = v.we; cpu_re = v.re; cpu_wdata = v.wdata;
    stall_n = 0; we_n = 0; re_n = 0; wc = 0; sel_o = '0; a_o = '0; wd_o = '0;
    rd_o = '0; done_clean = 1'b0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      if (per_sel != '0) begin
        per_ready = ~per_sel | ((v.dly >= 0 && wc >= v.dly) ? per_sel : 4'b0);
        wc++;
      end else begin
        per_ready = '1;
      end
      #1;
      if (!cpu_stall) begin
        ok = 1;
        rd_o = cpu_rdata;
        done_clean = (per_sel == '0) && !per_we && !per_re;
        break;
      end
      stall_n++;
      if (per_we) we_n++;
      if (per_re) re_n++;
      if (per_sel != '0) begin sel_o = per_sel; a_o = per_addr; wd_o = per_wdata; end
      @(negedge clk);
    end
    per_ready = '1;
    e = sb.pop_front();
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s completion: stall still high after 60 cycles, expected %0d stalled", tag, e.stall);
    end else begin
      chk({tag, " stall"}, stall_n, e.stall);
      chk({tag, " sel"}, sel_o, e.sel);
      chk({tag, " per_addr"}, a_o, e.paddr);
      chk({tag, " we_cyc"}, we_n, e.we_cyc);
      chk({tag, " re_cyc"}, re_n, e.re_cyc);
      chk({tag, " done_idle"}, done_clean, 1'b1);
      if (e.chk_rd) chk({tag, " rdata"}, rd_o, e.rdata);
      if (e.we && e.sel != '0) chk({tag, " per_wdata"}, wd_o, e.wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    #1;
    chk({tag, " err_flag"}, err_flag, e.err);
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0; per_ready = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst stall", cpu_stall, 1'b0);
    chk("rst err_flag", err_flag, 1'b0);
    chk("rst per_sel", per_sel, 4'b0);
    chk("rst strobes", {per_we, per_re}, 2'b00);
    chk("rst per_addr", per_addr, 2'b0);
    chk("rst per_wdata", per_wdata, 16'h0);
    chk("rst rdata", cpu_rdata, 16'hA5A5);

    vecs.push_back(mk(16'hC008, 0, 1, 16'h0000,  0, 1, 16'h1234, 2, 4'b0010, 2'd0, 0, 1, 0));
    vecs.push_back(mk(16'hC00F, 1, 0, 16'hBEEF,  2, 0, 16'h0000, 4, 4'b0100, 2'd3, 3, 0, 0));
    vecs.push_back(mk(16'hC001, 0, 1, 16'h0000,  0, 1, 16'hA5A5, 0, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(16'hC030, 1, 0, 16'h5555,  0, 0, 16'h0000, 0, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(16'hC013, 0, 1, 16'h0000, -1, 1, 16'hDEAD, 9, 4'b1000, 2'd3, 0, 8, 1));
    vecs.push_back(mk(16'hC03F, 0, 1, 16'h0000,  0, 1, 16'h0103, 0, 4'b0000, 2'd0, 0, 0, 1));
    vecs.push_back(mk(16'hC03F, 1, 0, 16'h0000,  0, 0, 16'h0000, 0, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(16'hC03F, 0, 1, 16'h0000,  0, 1, 16'h0000, 0, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(16'hC004, 1, 1, 16'h1111,  1, 0, 16'h0000, 3, 4'b0001, 2'd0, 2, 0, 0));
    vecs.push_back(mk(16'hC005, 0, 1, 16'h0000,  0, 1, 16'h0F0F, 2, 4'b0001, 2'd1, 0, 1, 0));
    vecs.push_back(mk(16'hC003, 0, 1, 16'h0000,  0, 1, 16'hA5A5, 0, 4'b0000, 2'd0, 0, 0, 0));
    vecs.push_back(mk(16'hC014, 0, 1, 16'h0000,  0, 1, 16'hA5A5, 0, 4'b0000, 2'd0, 0, 0, 0));
    foreach (vecs[i]) access(vecs[i], $sformatf("v%0d", i));

    // err_count saturation
    for (int i = 0; i < 300; i++)
      access(mk(16'hC004, 0, 1, 16'h0, -1, 1, 16'hDEAD, 9, 4'b0001, 2'd0, 0, 8, 1), "sat");
    access(mk(16'hC03F, 0, 1, 16'h0, 0, 1, 16'hFF00, 0, 4'b0, 2'd0, 0, 0, 1), "sat_status");
    access(mk(16'hC03F, 1, 0, 16'h0, 0, 0, 16'h0000, 0, 4'b0, 2'd0, 0, 0, 0), "sat_clear");

    // reset in the second WAIT cycle drops the access without an error
    cpu_addr = 16'hC008; cpu_re = 1'b1; per_ready = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstw stall_wait", cpu_stall, 1'b1);
    chk("rstw re_wait", per_re, 1'b1);
    rst = 1'b1; cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b0; per_ready = '1;
    #1;
    chk("rstw per_sel", per_sel, 4'b0);
    chk("rstw strobes", {per_we, per_re}, 2'b00);
    chk("rstw stall", cpu_stall, 1'b0);
    chk("rstw err_flag", err_flag, 1'b0);
    access(mk(16'hC008, 0, 1, 16'h0, 0, 1, 16'h1234, 2, 4'b0010, 2'd0, 0, 1, 0), "post_rst");
    access(mk(16'hC03F, 0, 1, 16'h0, 0, 1, 16'h0000, 0, 4'b0, 2'd0, 0, 0, 0), "post_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
